// File: rtl/riscv_pkg.sv
// Shared encodings for the writeback/load controller: result_src values,
// load funct3 codes and the controller FSM state type.
package riscv_pkg;

    localparam logic [1:0] RS_ALU = 2'b00;
    localparam logic [1:0] RS_MEM = 2'b01;
    localparam logic [1:0] RS_PC4 = 2'b10;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_MEM = 2'd1,
        COMMIT   = 2'd2
    } wb_state_t;

endpackage

// File: rtl/wb_load_ctrl_if.sv
// Instruction/cache inputs and register-file write port of wb_load_ctrl.
// master = pipeline side driving the instruction, slave = the controller.
interface wb_load_ctrl_if;
    logic        reg_write;
    logic [4:0]  rd;
    logic [1:0]  result_src;
    logic [31:0] alu_result;
    logic [31:0] pc_plus4;
    logic        mem_read;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [2:0]  load_funct3;
    logic [1:0]  addr_lo;
    logic [4:0]  a3;
    logic [31:0] wd3;
    logic        we3;
    logic        stall;
    logic        wb_timeout;

    modport master (
        output reg_write, rd, result_src, alu_result, pc_plus4, mem_read,
               mem_ready, mem_rdata, load_funct3, addr_lo,
        input  a3, wd3, we3, stall, wb_timeout
    );

    modport slave (
        input  reg_write, rd, result_src, alu_result, pc_plus4, mem_read,
               mem_ready, mem_rdata, load_funct3, addr_lo,
        output a3, wd3, we3, stall, wb_timeout
    );
endinterface

// File: rtl/load_extend.sv
// Load lane select and sign/zero extension of an aligned cache word.
// Byte lane = addr_lo, half lane = addr_lo[1]; unknown funct3 passes the word.
module load_extend
    import riscv_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [2:0]  funct3_i,
    input  logic [1:0]  addr_lo_i,
    output logic [31:0] ext_o
);
    logic [7:0]  byte_w;
    logic [15:0] half_w;

    // pick the lane, then extend according to the load type
    always_comb begin
        byte_w = rdata_i[{addr_lo_i, 3'b000} +: 8];
        half_w = addr_lo_i[1] ? rdata_i[31:16] : rdata_i[15:0];
        case (funct3_i)
            F3_LB:   ext_o = {{24{byte_w[7]}}, byte_w};
            F3_LH:   ext_o = {{16{half_w[15]}}, half_w};
            F3_LBU:  ext_o = {24'd0, byte_w};
            F3_LHU:  ext_o = {16'd0, half_w};
            F3_LW:   ext_o = rdata_i;
            default: ext_o = rdata_i;
        endcase
    end
endmodule

// File: rtl/wb_load_ctrl.sv
// Writeback / load-miss controller. Hits write back combinationally; a load
// miss stalls, waits for the cache, registers the extended word and commits
// it one cycle later. Optional WAIT_MEM timeout under macro WB_TIMEOUT_EN.
module wb_load_ctrl
    import riscv_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic          clk,
    input  logic          rst,
    wb_load_ctrl_if.slave bus
);
    wb_state_t   state_q, state_d, out_state;
    logic [4:0]  rd_q, rd_d;
    logic [2:0]  f3_q, f3_d;
    logic [1:0]  alo_q, alo_d;
    logic        rw_q, rw_d;
    logic [31:0] data_q, data_d;

    logic [4:0]  a3_w;
    logic [31:0] wd3_w, ext_w;
    logic        we3_w, stall_w;
    logic [2:0]  ext_f3;
    logic [1:0]  ext_alo;

`ifdef WB_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;
    assign bus.wb_timeout = tmo_q;
`else
    logic [31:0] unused_timeout_cfg;
    assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
    assign bus.wb_timeout = 1'b0;
`endif

    // while reset is held the outputs behave as in IDLE
    assign out_state = rst ? IDLE : state_q;

    // a waiting miss extends with its captured type; otherwise the live one
    assign ext_f3  = (out_state == WAIT_MEM) ? f3_q  : bus.load_funct3;
    assign ext_alo = (out_state == WAIT_MEM) ? alo_q : bus.addr_lo;

    load_extend u_ext (
        .rdata_i  (bus.mem_rdata),
        .funct3_i (ext_f3),
        .addr_lo_i(ext_alo),
        .ext_o    (ext_w)
    );

    // next state, capture and write-port drive
    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        f3_d    = f3_q;
        alo_d   = alo_q;
        rw_d    = rw_q;
        data_d  = data_q;
        a3_w    = bus.rd;
        wd3_w   = '0;
        we3_w   = 1'b0;
        stall_w = 1'b0;
`ifdef WB_TIMEOUT_EN
        cnt_d   = '0;
        tmo_d   = tmo_q;
`endif
        case (out_state)
            WAIT_MEM: begin
                a3_w    = rd_q;
                stall_w = 1'b1;
                if (bus.mem_ready) begin
                    data_d  = ext_w;
                    state_d = COMMIT;
                end
`ifdef WB_TIMEOUT_EN
                else if (cnt_q == TMO_LAST) begin
                    tmo_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
`endif
            end
            COMMIT: begin
                a3_w    = rd_q;
                wd3_w   = data_q;
                we3_w   = rw_q && (rd_q != 5'd0);
                state_d = IDLE;
            end
            default: begin
                case (bus.result_src)
                    RS_MEM:  wd3_w = ext_w;
                    RS_PC4:  wd3_w = bus.pc_plus4;
                    default: wd3_w = bus.alu_result;
                endcase
                we3_w = bus.reg_write && (bus.rd != 5'd0);
                if (bus.mem_read && !bus.mem_ready) begin
                    stall_w = 1'b1;
                    we3_w   = 1'b0;
                    rd_d    = bus.rd;
                    f3_d    = bus.load_funct3;
                    alo_d   = bus.addr_lo;
                    rw_d    = bus.reg_write;
                    state_d = WAIT_MEM;
                end
            end
        endcase
    end

    // state and capture registers, synchronous reset drops any pending load
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            rd_q    <= '0;
            f3_q    <= '0;
            alo_q   <= '0;
            rw_q    <= 1'b0;
            data_q  <= '0;
`ifdef WB_TIMEOUT_EN
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            rd_q    <= rd_d;
            f3_q    <= f3_d;
            alo_q   <= alo_d;
            rw_q    <= rw_d;
            data_q  <= data_d;
`ifdef WB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
`endif
        end
    end

    assign bus.a3    = a3_w;
    assign bus.wd3   = wd3_w;
    assign bus.we3   = we3_w;
    assign bus.stall = stall_w;
endmodule

// File: doc/wb_load_ctrl.md
WB_LOAD_CTRL -- requirements
Module: wb_load_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 255, max WAIT_MEM cycles before timeout (used only with WB_TIMEOUT_EN).
REQ-002 SHALL have port clk  in  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have port reg_write  in  1  decoded register-write enable of current instruction.
REQ-005 SHALL have port rd  in  5  destination register index.
REQ-006 SHALL have port result_src  in  2  00 ALU, 01 memory, 10 PC+4, 11 treated as ALU.
REQ-007 SHALL have ports alu_result, pc_plus4  in  32 each  writeback candidates.
REQ-008 SHALL have port mem_read  in  1  current instruction is a load.
REQ-009 SHALL have port mem_ready  in  1  data cache returns valid mem_rdata this cycle.
REQ-010 SHALL have port mem_rdata  in  32  aligned cache word.
REQ-011 SHALL have ports load_funct3  in  3 and addr_lo  in  2  load size/sign and byte offset.
REQ-012 SHALL have outputs a3  5, wd3  32, we3  1, which drive the register-file write port.
REQ-013 SHALL have output stall  1  holds PC/fetch when high.
REQ-014 SHALL have output wb_timeout  1  sticky load-timeout flag.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT_MEM, COMMIT.
REQ-016 IDLE, non-load or load with mem_ready=1: SHALL combinationally drive a3=rd, wd3=selected/extended result, we3=reg_write&(rd!=0), stall=0 (zero-latency hit path).
REQ-017 IDLE, mem_read=1 & mem_ready=0: SHALL drive stall=1, we3=0, capture rd, load_funct3, addr_lo, reg_write, and move to WAIT_MEM next edge.
REQ-018 WAIT_MEM: SHALL hold stall=1, we3=0, and ignore all instruction inputs except mem_ready/mem_rdata.
REQ-019 WAIT_MEM & mem_ready=1: SHALL register the extended mem_rdata and move to COMMIT.
REQ-020 COMMIT: SHALL drive a3=captured rd, wd3=captured data, we3=captured reg_write&(captured rd!=0), stall=0, then return to IDLE; new mem_read in COMMIT SHALL NOT start a new miss.
REQ-021 Extension SHALL follow funct3: 000 LB sign, 001 LH sign, 010 LW, 100 LBU zero, 101 LHU zero; byte lane=addr_lo, half lane=addr_lo[1]; other codes SHALL pass the full word.
REQ-022 we3 SHALL never assert with a3=0.

Reset
REQ-023 rst=1 SHALL force IDLE, clear captured rd/data/controls and timeout counter, and clear wb_timeout at the next edge.
REQ-024 rst during WAIT_MEM or COMMIT SHALL discard the pending load with no register write.
REQ-025 During rst, outputs SHALL follow the IDLE combinational rules.

Configuration
REQ-026 Macro WB_TIMEOUT_EN defined: an 8-bit-or-wider counter SHALL count WAIT_MEM cycles; on reaching TIMEOUT_CYCLES, wb_timeout SHALL set (sticky until rst) and FSM SHALL enter IDLE with no write.
REQ-027 Without WB_TIMEOUT_EN: no counter is present, wb_timeout SHALL be tied 0, and WAIT_MEM SHALL wait indefinitely.

Structure
REQ-028 Shared package riscv_pkg SHALL hold result_src encodings, load funct3 constants, and the FSM state type.
REQ-029 Sub-module load_extend (combinational lane select plus sign/zero extension) SHALL be instantiated once, on the mem_rdata path.

Verification
REQ-030 ALU op: reg_write=1, rd=5, alu_result=0x1234 -> same cycle a3=5, wd3=0x1234, we3=1, stall=0.
REQ-031 Hit LB: mem_ready=1, mem_rdata=0x80FF7F01, addr_lo=3 -> wd3=0xFFFFFF80, no stall.
REQ-032 Miss LHU rd=7: mem_ready low 3 cycles then mem_rdata=0xBEEF1234, addr_lo=2 -> stall high 4 cycles, COMMIT writes x7=0x0000BEEF, stall=0.
REQ-033 Load to rd=0 miss -> full stall sequence, we3 never asserted.
REQ-034 rst asserted in WAIT_MEM -> next cycle IDLE, stall=0, no write follows.
REQ-035 With WB_TIMEOUT_EN, TIMEOUT_CYCLES=4, mem_ready held 0 -> wb_timeout=1 after 4 WAIT_MEM cycles, FSM IDLE, no write.
